// File: rtl/blk_mem_responder.sv
// blk_mem_responder: serves 256-bit block read/write requests as eight word accesses on a word memory.
module blk_mem_responder #(
  parameter int LATENCY = 4,
  parameter int WORDS = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                blk_read_req,
  input  logic                blk_write_req,
  input  logic [31:0]         blk_address,
  input  logic [32*WORDS-1:0] blk_write_data,
  output logic [32*WORDS-1:0] blk_read_data,
  output logic                blk_read_valid,
  output logic                blk_write_valid,
  output logic [31:0]         mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [31:0]         mem_write_data,
  input  logic [31:0]         mem_read_data,
  input  logic                mem_ready
);
  localparam int IW = $clog2(WORDS);
  localparam logic [7:0] LAT_LAST = 8'(LATENCY - 1);
  typedef enum logic [2:0] {IDLE, WAIT, XFER, DONE, DROP} state_t;
  state_t state_q, state_d;
  logic op_q, op_d;
  logic [26:0] addr_q, addr_d;
  logic [32*WORDS-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0] lat_q, lat_d;
  logic [IW-1:0] idx_q, idx_d;
  logic start, act_req, last, xfer;
  logic unused_addr_bits;
  assign unused_addr_bits = ^blk_address[4:0];
  assign start = blk_read_req | blk_write_req;
  // op_q=1 marks a write; the request being served decides abort and release
  assign act_req = op_q ? blk_write_req : blk_read_req;
  assign last = idx_q == IW'(WORDS - 1);
  always_ff @(posedge CLK) begin
    if (!RESET) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = start ? (LATENCY == 0 ? XFER : WAIT) : IDLE;
      WAIT: state_d = !act_req ? IDLE : (lat_q == LAT_LAST ? XFER : WAIT);
      XFER: state_d = !act_req ? IDLE : (mem_ready && last ? DONE : XFER);
      DONE: state_d = DROP;
      DROP: state_d = act_req ? DROP : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    op_d = op_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    lat_d = lat_q;
    idx_d = idx_q;
    if (state_q == IDLE && start) begin
      op_d = !blk_read_req;
      addr_d = blk_address[31:5];
      wdata_d = blk_read_req ? wdata_q : blk_write_data;
      lat_d = '0;
      idx_d = '0;
    end
    if (state_q == WAIT) lat_d = lat_q + 8'd1;
    if (state_q == XFER && mem_ready) begin
      idx_d = idx_q + IW'(1);
      if (!op_q) rdata_d[32*idx_q +: 32] = mem_read_data;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      op_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lat_q <= '0;
      idx_q <= '0;
    end else begin
      op_q <= op_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      lat_q <= lat_d;
      idx_q <= idx_d;
    end
  end
  always_comb begin
    xfer = state_q == XFER;
    mem_read = xfer & ~op_q;
    mem_write = xfer & op_q;
    mem_address = xfer ? {addr_q, idx_q, 2'b00} : '0;
    mem_write_data = mem_write ? wdata_q[32*idx_q +: 32] : '0;
    blk_read_valid = state_q == DONE && !op_q;
    blk_write_valid = state_q == DONE && op_q;
    blk_read_data = rdata_q;
  end
endmodule
